// File: rtl/matmul_ctrl_pkg.sv
// Shared definitions for the 8x8 matmul sequencer: sizing constants and FSM states.
package matmul_ctrl_pkg;

  localparam int DWIDTH  = 8;
  localparam int AWIDTH  = 7;
  localparam int BB_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/matmul_seq_counter.sv
// Loadable up-counter that stops at a run-time terminal value and flags it.
module matmul_seq_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == terminal);

  // Count register: load wins over increment; holds once the terminal value is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/matmul_8x8_sequencer.sv
// Host-command sequencer for one 8x8 systolic matmul: start, wait, drain C rows, gap, respond.
module matmul_8x8_sequencer
  import matmul_ctrl_pkg::*;
#(
  parameter int DWIDTH     = matmul_ctrl_pkg::DWIDTH,
  parameter int AWIDTH     = matmul_ctrl_pkg::AWIDTH,
  parameter int BB_SIZE    = matmul_ctrl_pkg::BB_SIZE,
  parameter int TIMEOUT    = 255,
  parameter int GAP_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [AWIDTH-1:0]         cmd_c_base,
  output logic                      rsp_done,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      start_mat_mul,
  input  logic                      done_mat_mul,
  input  logic [BB_SIZE*DWIDTH-1:0] c_data_row_0,
  input  logic [BB_SIZE*DWIDTH-1:0] c_data_row_1,
  output logic                      c_wr_en,
  output logic [AWIDTH-1:0]         c_addr,
  output logic [BB_SIZE*DWIDTH-1:0] c_wdata_0,
  output logic [BB_SIZE*DWIDTH-1:0] c_wdata_1
);

  localparam int CW = $clog2(((TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES) + 1);
  localparam int IW = (BB_SIZE > 1) ? $clog2(BB_SIZE) : 1;

  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] DRAIN_LAST = IW'(BB_SIZE - 1);

  state_t            state, state_next;
  logic [AWIDTH-1:0] c_base;
  logic              err;
  logic              accept;
  logic              timeout_hit;

  logic              tmr_load, tmr_en, tmr_tc;
  logic [CW-1:0]     tmr_terminal, tmr_count;
  logic              idx_load, idx_en, idx_tc;
  logic [IW-1:0]     idx_count;

  logic              rsp_done_next;
  logic [AWIDTH-1:0] addr_offset;

  assign accept = (state == IDLE) && cmd_valid && cmd_ready;

  // One counter serves both RUN (timeout) and GAP (minimum low time) since they never overlap.
  matmul_seq_counter #(.WIDTH(CW)) u_tmr (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value ('0),
    .en         (tmr_en),
    .terminal   (tmr_terminal),
    .count      (tmr_count),
    .tc         (tmr_tc)
  );

  matmul_seq_counter #(.WIDTH(IW)) u_idx (
    .clk        (clk),
    .reset      (reset),
    .load       (idx_load),
    .load_value ('0),
    .en         (idx_en),
    .terminal   (DRAIN_LAST),
    .count      (idx_count),
    .tc         (idx_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and counter control; done in the timeout cycle takes the DRAIN path.
  always_comb begin
    state_next   = state;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    idx_load     = 1'b0;
    idx_en       = 1'b0;
    timeout_hit  = 1'b0;
    tmr_terminal = (state == GAP) ? GAP_LAST : TMO_LAST;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
          tmr_load   = 1'b1;
        end
      end
      RUN: begin
        tmr_en = 1'b1;
        if (done_mat_mul) begin
          state_next = DRAIN;
          idx_load   = 1'b1;
        end else if (tmr_tc) begin
          state_next  = GAP;
          tmr_load    = 1'b1;
          timeout_hit = 1'b1;
        end
      end
      DRAIN: begin
        idx_en = 1'b1;
        if (idx_tc) begin
          state_next = GAP;
          tmr_load   = 1'b1;
        end
      end
      GAP: begin
        tmr_en = 1'b1;
        if (tmr_tc && !done_mat_mul) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write address offset for the upcoming drain beat (0 on entry, idx+1 while draining).
  always_comb begin
    addr_offset   = '0;
    rsp_done_next = (state == GAP) && (state_next == IDLE);
    if (state == DRAIN) begin
      addr_offset = AWIDTH'(idx_count) + AWIDTH'(1);
    end
  end

  // Registered outputs, command latch and error status.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      start_mat_mul <= 1'b0;
      c_wr_en       <= 1'b0;
      rsp_done      <= 1'b0;
      rsp_err       <= 1'b0;
      err           <= 1'b0;
      c_base        <= '0;
      c_addr        <= '0;
      c_wdata_0     <= '0;
      c_wdata_1     <= '0;
    end else begin
      cmd_ready     <= (state_next == IDLE);
      busy          <= (state_next != IDLE);
      start_mat_mul <= (state_next == RUN) || (state_next == DRAIN);
      c_wr_en       <= (state_next == DRAIN);
      rsp_done      <= rsp_done_next;
      if (accept) begin
        c_base  <= cmd_c_base;
        err     <= 1'b0;
        rsp_err <= 1'b0;
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end
      if (rsp_done_next) begin
        rsp_err <= err;
      end
      if (state_next == DRAIN) begin
        c_addr    <= c_base + addr_offset;
        c_wdata_0 <= c_data_row_0;
        c_wdata_1 <= c_data_row_1;
      end
    end
  end

endmodule

// File: tb/tb_matmul_8x8_sequencer.sv
// Scoreboard bench for matmul_8x8_sequencer: writes and responses checked by a negedge monitor.
module tb_matmul_8x8_sequencer;

  localparam int DW   = 8;
  localparam int AW   = 7;
  localparam int BB   = 4;
  localparam int TMO  = 255;
  localparam int GAPC = 2;
  localparam int RW   = BB * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_c_base = '0;
  logic          rsp_done, rsp_err, busy, start_mat_mul;
  logic          done_mat_mul = 1'b0;
  logic [RW-1:0] row0 = '0;
  logic [RW-1:0] row1 = '0;
  logic          c_wr_en;
  logic [AW-1:0] c_addr;
  logic [RW-1:0] c_wdata_0, c_wdata_1;

  matmul_8x8_sequencer #(
    .DWIDTH    (DW),
    .AWIDTH    (AW),
    .BB_SIZE   (BB),
    .TIMEOUT   (TMO),
    .GAP_CYCLES(GAPC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_c_base   (cmd_c_base),
    .rsp_done     (rsp_done),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .start_mat_mul(start_mat_mul),
    .done_mat_mul (done_mat_mul),
    .c_data_row_0 (row0),
    .c_data_row_1 (row1),
    .c_wr_en      (c_wr_en),
    .c_addr       (c_addr),
    .c_wdata_0    (c_wdata_0),
    .c_wdata_1    (c_wdata_1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int start_cycles = 0;
  int rsp_seen = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] d0;
    logic [RW-1:0] d1;
    int            cyc;
  } wr_exp_t;

  typedef struct {
    logic err;
    int   cyc;
  } rsp_exp_t;

  wr_exp_t  wq[$];
  rsp_exp_t rq[$];
  wr_exp_t  mon_w;
  rsp_exp_t mon_r;

  // Monitor: pops expected writes/responses as the DUT produces them.
  always @(negedge clk) begin
    if (!reset) begin
      if (start_mat_mul === 1'b1) start_cycles++;
      if (busy === 1'b1) begin
        checks++;
        if (cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_while_busy cyc=%0d got=%b exp=0", cyc, cmd_ready);
        end
      end
      if (c_wr_en !== 1'b0) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write cyc=%0d wr_en=%b addr=%h", cyc, c_wr_en, c_addr);
        end else begin
          mon_w = wq.pop_front();
          if (c_addr !== mon_w.addr || c_wdata_0 !== mon_w.d0 || c_wdata_1 !== mon_w.d1 ||
              cyc != mon_w.cyc) begin
            errors++;
            $display("FAIL c_write got addr=%h d0=%h d1=%h cyc=%0d exp addr=%h d0=%h d1=%h cyc=%0d",
                     c_addr, c_wdata_0, c_wdata_1, cyc, mon_w.addr, mon_w.d0, mon_w.d1, mon_w.cyc);
          end
        end
      end
      if (rsp_done !== 1'b0) begin
        rsp_seen++;
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp cyc=%0d rsp_done=%b", cyc, rsp_done);
        end else begin
          mon_r = rq.pop_front();
          if (rsp_err !== mon_r.err || cyc != mon_r.cyc) begin
            errors++;
            $display("FAIL rsp got err=%b cyc=%0d exp err=%b cyc=%0d",
                     rsp_err, cyc, mon_r.err, mon_r.cyc);
          end
        end
      end
    end
  end

  // One full operation: done after t RUN cycles (or never when tmo), done kept high done_extra cycles after.
  task automatic run_op(input logic [AW-1:0] base, input int t, input bit tmo,
                        input int done_extra, input bit keep_valid, output int acc);
    int k, d, x, snap_rsp, snap_start, exp_start;
    rsp_exp_t r;
    wr_exp_t  w;
    cmd_c_base = base;
    cmd_valid  = 1'b1;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept_wait got ready=%b exp=1", cmd_ready);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc      = cyc;
    snap_rsp = rsp_seen;
    d        = acc + 1 + t;
    if (tmo) begin
      r.err = 1'b1;
      r.cyc = acc + TMO + GAPC + 1;
    end else begin
      x     = (d + BB + GAPC > d + done_extra + 1) ? d + BB + GAPC : d + done_extra + 1;
      r.err = 1'b0;
      r.cyc = x + 1;
    end
    rq.push_back(r);
    @(posedge clk); #1;
    if (!keep_valid) cmd_valid = 1'b0;
    snap_start = start_cycles;
    if (!tmo) begin
      repeat (t) begin @(posedge clk); #1; end
      done_mat_mul = 1'b1;
      for (int i = 0; i < BB; i++) begin
        row0   = $urandom;
        row1   = $urandom;
        w.addr = base + AW'(i);
        w.d0   = row0;
        w.d1   = row1;
        w.cyc  = d + 1 + i;
        wq.push_back(w);
        @(posedge clk); #1;
        done_mat_mul = (i + 1 <= done_extra);
      end
      for (int j = BB + 1; j <= done_extra + 1; j++) begin
        @(posedge clk); #1;
        done_mat_mul = (j <= done_extra);
      end
    end
    exp_start = tmo ? TMO : t + 1 + BB;
    k = 0;
    while (rsp_seen == snap_rsp && k < 600) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (rsp_seen == snap_rsp) begin
      errors++;
      $display("FAIL rsp_wait got rsp_count=%0d exp=%0d", rsp_seen, snap_rsp + 1);
    end
    checks++;
    if (start_cycles - snap_start != exp_start) begin
      errors++;
      $display("FAIL start_len got=%0d exp=%0d", start_cycles - snap_start, exp_start);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({start_mat_mul, c_wr_en, rsp_done, rsp_err, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {start_mat_mul, c_wr_en, rsp_done, rsp_err, busy});
    end
    checks++;
    if (c_addr !== '0 || c_wdata_0 !== '0 || c_wdata_1 !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h d0=%h d1=%h exp=0", c_addr, c_wdata_0, c_wdata_1);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b busy=%b exp ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic();
    int a;
    run_op(7'h10, 12, 1'b0, 0, 1'b0, a);
  endtask

  task automatic test_wrap();
    int a;
    run_op(7'h7E, 3, 1'b0, 0, 1'b0, a);
  endtask

  task automatic test_timeout();
    int a;
    run_op(7'h05, 0, 1'b1, 0, 1'b0, a);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (rsp_err !== 1'b1 || rsp_done !== 1'b0) begin
      errors++;
      $display("FAIL err_hold got err=%b done=%b exp err=1 done=0", rsp_err, rsp_done);
    end
  endtask

  task automatic test_done_wins();
    int a;
    run_op(7'h40, TMO - 1, 1'b0, 0, 1'b0, a);
  endtask

  task automatic test_done_extend();
    int a;
    run_op(7'h50, 2, 1'b0, BB + 5, 1'b0, a);
  endtask

  task automatic test_back_to_back();
    int a1, a2;
    run_op(7'h20, 1, 1'b0, 0, 1'b1, a1);
    run_op(7'h20, 4, 1'b0, 0, 1'b0, a2);
    checks++;
    if (a2 != a1 + 1 + 2 + BB + GAPC) begin
      errors++;
      $display("FAIL b2b_accept got=%0d exp=%0d", a2, a1 + 1 + 2 + BB + GAPC);
    end
  endtask

  task automatic test_spurious_done();
    done_mat_mul = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, start_mat_mul, c_wr_en, rsp_done, cmd_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL idle_done got=%b exp=00001",
                 {busy, start_mat_mul, c_wr_en, rsp_done, cmd_ready});
      end
    end
    done_mat_mul = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    int k, d;
    wr_exp_t w;
    cmd_c_base = 7'h30;
    cmd_valid  = 1'b1;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    d = cyc + 1 + 3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    done_mat_mul = 1'b1;
    for (int i = 0; i < 3; i++) begin
      row0   = $urandom;
      row1   = $urandom;
      w.addr = 7'h30 + AW'(i);
      w.d0   = row0;
      w.d1   = row1;
      w.cyc  = d + 1 + i;
      wq.push_back(w);
      @(posedge clk); #1;
      done_mat_mul = 1'b0;
    end
    @(negedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({start_mat_mul, c_wr_en, busy, rsp_done} !== 4'b0 || c_addr !== '0) begin
      errors++;
      $display("FAIL mid_drain_reset got ctrl=%b addr=%h exp ctrl=0000 addr=00",
               {start_mat_mul, c_wr_en, busy, rsp_done}, c_addr);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain_ready got ready=%b busy=%b exp ready=1 busy=0", cmd_ready, busy);
    end
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL mid_drain_writes got pending=%0d exp=0", wq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_done_wins();
    test_done_extend();
    test_back_to_back();
    test_spurious_done();
    test_reset_mid_drain();
    test_basic();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got wq=%0d rq=%0d exp=0", wq.size(), rq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
